// File: rtl/imem_access_ctrl_if.sv
// Fetch and loader request bus seen by the instruction memory access controller.
interface imem_access_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_done;

  // Controller side
  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, ld_wdata, ld_done,
    output if_gnt, if_rvalid, if_rdata, ld_gnt
  );

  // Fetch stage / loader side
  modport master (
    output if_req, if_addr, ld_req, ld_addr, ld_wdata, ld_done,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Instruction memory access controller: loader-only BOOT phase, then RUN with
// loader priority and a bounded fetch starvation window.
module imem_access_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_access_ctrl_if.slave    bus,
  output logic                 core_run,
  output logic                 addr_err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q;
  logic          rvalid_q;
  logic          nop_q;
  logic          err_q;
  logic          if_gnt_c;
  logic          ld_gnt_c;
  logic          if_bad_c;
  logic          ld_bad_c;

  // Misaligned or beyond the last word of the array
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  assign if_bad_c = addr_bad(bus.if_addr);
  assign ld_bad_c = addr_bad(bus.ld_addr);

  // Next state and arbitration; at most one grant, none while in reset
  always_comb begin
    state_d  = state_q;
    if_gnt_c = 1'b0;
    ld_gnt_c = 1'b0;
    case (state_q)
      BOOT: begin
        ld_gnt_c = bus.ld_req;
        if (bus.ld_done) state_d = RUN;
      end
      RUN: begin
        if ((wait_q == WW'(MAX_WAIT)) && bus.if_req) if_gnt_c = 1'b1;
        else if (bus.ld_req)                         ld_gnt_c = 1'b1;
        else if (bus.if_req)                         if_gnt_c = 1'b1;
      end
      default: state_d = BOOT;
    endcase
    if (rst) begin
      if_gnt_c = 1'b0;
      ld_gnt_c = 1'b0;
    end
  end

  assign bus.if_gnt = if_gnt_c;
  assign bus.ld_gnt = ld_gnt_c;

  // Memory strobe only for well-formed granted accesses; bad ones are consumed silently
  assign mem_en    = (if_gnt_c & ~if_bad_c) | (ld_gnt_c & ~ld_bad_c);
  assign mem_we    = ld_gnt_c;
  assign mem_addr  = ld_gnt_c ? bus.ld_addr[AW+1:2] : bus.if_addr[AW+1:2];
  assign mem_wdata = bus.ld_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Count consecutive RUN cycles a pending fetch was refused, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if (state_q == RUN) begin
      if (if_gnt_c)                                      wait_q <= '0;
      else if (bus.if_req && (wait_q != WW'(MAX_WAIT)))  wait_q <= wait_q + WW'(1);
    end
  end

  // Track the fetch whose data returns next cycle and whether it was a bad one
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      nop_q    <= 1'b0;
    end else begin
      rvalid_q <= if_gnt_c;
      nop_q    <= if_gnt_c & if_bad_c;
    end
  end

  // Sticky address error flag
  always_ff @(posedge clk) begin
    if (rst)                                                 err_q <= 1'b0;
    else if ((if_gnt_c & if_bad_c) | (ld_gnt_c & ld_bad_c))  err_q <= 1'b1;
  end

  // Reset squashes a read return already in flight
  assign bus.if_rvalid = rvalid_q & ~rst;
  assign bus.if_rdata  = bus.if_rvalid ? (nop_q ? NOP_WORD : mem_rdata) : 32'h0;
  assign core_run      = (state_q == RUN);
  assign addr_err      = err_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_imem_access_ctrl;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned MAX_WAIT = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int unsigned AW       = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          core_run;
  logic          addr_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  imem_access_ctrl_if bus ();

  imem_access_ctrl #(
    .DEPTH   (DEPTH),
    .MAX_WAIT(MAX_WAIT),
    .NOP_WORD(NOP_WORD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .core_run (core_run),
    .addr_err (addr_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory array attached to the controller
  logic [31:0] tmem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= tmem[mem_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          m_run;
  int          m_denied;
  bit          m_err;
  bit          m_pend;
  logic [31:0] m_pend_data;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  // One clock cycle: drive inputs, compare outputs to the model, advance the model
  task automatic cycle(input bit irq, input logic [31:0] ia, input bit lrq,
                       input logic [31:0] la, input logic [31:0] wd,
                       input bit done, input bit r);
    bit          e_ig, e_lg, e_en, ibad, lbad, e_rv;
    logic [31:0] e_rd;
    bus.if_req   = irq;
    bus.if_addr  = ia;
    bus.ld_req   = lrq;
    bus.ld_addr  = la;
    bus.ld_wdata = wd;
    bus.ld_done  = done;
    rst          = r;
    #3;
    ibad = is_bad(ia);
    lbad = is_bad(la);
    e_ig = 1'b0;
    e_lg = 1'b0;
    if (!r) begin
      if (!m_run)                             e_lg = lrq;
      else if (irq && m_denied >= MAX_WAIT)   e_ig = 1'b1;
      else if (lrq)                           e_lg = 1'b1;
      else                                    e_ig = irq;
    end
    e_en = (e_ig && !ibad) || (e_lg && !lbad);
    e_rv = m_pend && !r;
    e_rd = e_rv ? m_pend_data : 32'h0;
    check("if_gnt",    32'(bus.if_gnt),    32'(e_ig));
    check("ld_gnt",    32'(bus.ld_gnt),    32'(e_lg));
    check("mem_en",    32'(mem_en),        32'(e_en));
    check("if_rvalid", 32'(bus.if_rvalid), 32'(e_rv));
    check("if_rdata",  bus.if_rdata,       e_rd);
    check("core_run",  32'(core_run),      32'(m_run));
    check("addr_err",  32'(addr_err),      32'(m_err));
    if (e_en) begin
      check("mem_we",   32'(mem_we),   32'(e_lg));
      check("mem_addr", 32'(mem_addr), e_lg ? la / 4 : ia / 4);
      if (e_lg) check("mem_wdata", mem_wdata, wd);
    end
    if (r) begin
      m_run = 0; m_denied = 0; m_err = 0; m_pend = 0;
    end else begin
      m_pend      = e_ig;
      m_pend_data = ibad ? NOP_WORD : ref_mem[ia / 4];
      if (e_lg && !lbad) ref_mem[la / 4] = wd;
      if ((e_ig && ibad) || (e_lg && lbad)) m_err = 1;
      if (m_run) begin
        if (e_ig)                         m_denied = 0;
        else if (irq && m_denied < MAX_WAIT) m_denied++;
      end
      if (!m_run && done) m_run = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom;
    else                           a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    return a;
  endfunction

  initial begin
    logic [31:0] w;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    m_run = 0; m_denied = 0; m_err = 0; m_pend = 0; m_pend_data = 32'h0;
    bus.if_req = 0; bus.if_addr = 0; bus.ld_req = 0; bus.ld_addr = 0;
    bus.ld_wdata = 0; bus.ld_done = 0; rst = 1;
    @(posedge clk);
    #1;

    // 1: boot with fetch held, two loads, done pulse, first fetch
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 32'h0, 32'h0050_0093, 0, 0);
    cycle(1, 0, 1, 32'h4, 32'h00a0_0113, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("t1_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("t1_rdata",  bus.if_rdata,       32'h0050_0093);
    idle(1);

    // 2: back-to-back fetches
    cycle(1, 32'h0, 0, 0, 0, 0, 0);
    cycle(1, 32'h4, 0, 0, 0, 0, 0);
    cycle(1, 32'h8, 0, 0, 0, 0, 0);
    check("t2_rdata_last", bus.if_rdata, 32'h0);
    idle(2);

    // 3: both requesters held, fetch forced through every MAX_WAIT+1 cycles
    for (int i = 0; i < 15; i++)
      cycle(1, 32'h4, 1, 32'(16 + i) * 4, 32'hA500_0000 | 32'(i), 0, 0);
    idle(2);

    // 4: misaligned fetch, out-of-range load, re-read of word 0
    cycle(1, 32'h2, 0, 0, 0, 0, 0);
    check("t4_nop", bus.if_rdata, NOP_WORD);
    cycle(0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0);
    cycle(1, 32'h0, 0, 0, 0, 0, 0);
    check("t4_word0", bus.if_rdata, 32'h0050_0093);
    check("t4_err",   32'(addr_err), 32'h1);
    idle(1);

    // 5: reset right after a fetch grant, fetch blocked in BOOT
    cycle(1, 32'h4, 0, 0, 0, 0, 0);
    cycle(1, 32'h4, 0, 0, 0, 0, 1);
    cycle(1, 32'h4, 0, 0, 0, 0, 0);
    check("t5_core_run", 32'(core_run), 32'h0);
    cycle(1, 32'h4, 0, 0, 0, 0, 0);

    // 6: write together with done, later done ignored, read-after-write
    cycle(0, 0, 1, 32'hC, 32'h1234_5678, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 32'h10, 32'hCAFE_F00D, 0, 0);
    cycle(1, 32'h10, 0, 0, 0, 0, 0);
    check("t6_raw", bus.if_rdata, 32'hCAFE_F00D);
    cycle(1, 32'hC, 0, 0, 0, 0, 0);
    check("t6_boot_write", bus.if_rdata, 32'h1234_5678);
    idle(1);

    // Random traffic including occasional resets and done pulses
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      cycle($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 2) == 0,
            rand_addr(), w, $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
